bus_fifo_feeder: RTL and testbench

- Buffered ingress stage that sits directly upstream of the D-type register stage.
- Accepts Bus_t words over a valid/ready handshake and stores them in a circular FIFO.
- Drains one word per cycle into the register stage as an enable/data pair (o_E, o_D). The output connects straight to that stage's i_E and i_D.
- A downstream hold input pauses draining. A sticky overflow flag records writes that were refused.

---
 rtl/bus_fifo_feeder_pkg.sv | 14 +
 rtl/bus_fifo_feeder_fifo_ptr.sv | 20 ++
 rtl/bus_fifo_feeder.sv | 80 ++++++++
 tb/tb_bus_fifo_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_fifo_feeder_pkg.sv
// Shared bus definitions used by the register stage and its ingress FIFO.
package bus_fifo_feeder_pkg;

   localparam int unsigned BUS_W      = 12;
   localparam int unsigned TAG_W      = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned FIFO_DEPTH = 8;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } Bus_t;

endpackage

// File: rtl/bus_fifo_feeder_fifo_ptr.sv
// Circular FIFO pointer: advances on i_inc, wrapping DEPTH-1 -> 0.
module fifo_ptr #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ptr <= '0;
      end else if (i_inc) begin
         o_ptr <= (o_ptr == PTR_W'(DEPTH - 1)) ? '0 : o_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/bus_fifo_feeder.sv
// Buffered ingress stage: valid/ready in, one word per cycle out as an
// enable/data pair for the downstream register stage.
module bus_fifo_feeder
   import bus_fifo_feeder_pkg::*;
#(
   parameter  int unsigned DEPTH = FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  Bus_t             i_D,
   input  logic             i_hold,
   output logic             o_E,
   output Bus_t             o_D,
   output logic [CNT_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_ovf
);

   Bus_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign o_empty = (o_count == '0);
   assign o_full  = (o_count == CNT_W'(DEPTH));
   assign o_ready = !o_full;

   // No bypass: a word becomes drainable only once it is counted.
   assign wr_en = i_valid && o_ready;
   assign rd_en = !o_empty && !i_hold;

   fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (wr_en),
      .o_ptr   (wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (rd_en),
      .o_ptr   (rd_ptr)
   );

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= i_D;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
         o_E     <= 1'b0;
         o_D     <= '0;
         o_ovf   <= 1'b0;
      end else begin
         o_E <= rd_en;
         if (rd_en) begin
            o_D <= mem[rd_ptr];
         end
         case ({wr_en, rd_en})
            2'b10:   o_count <= o_count + CNT_W'(1);
            2'b01:   o_count <= o_count - CNT_W'(1);
            default: o_count <= o_count;
         endcase
         if (i_valid && o_full) begin
            o_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_fifo_feeder.sv
// Scoreboard bench for bus_fifo_feeder: accepted words are queued by a
// cycle model and checked against each o_E/o_D the DUT produces.
module tb_bus_fifo_feeder;
   import bus_fifo_feeder_pkg::*;

   localparam int unsigned DEPTH = FIFO_DEPTH;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             i_clk;
   logic             i_rst_n;
   logic             i_valid;
   logic             o_ready;
   Bus_t             i_D;
   logic             i_hold;
   logic             o_E;
   Bus_t             o_D;
   logic [CNT_W-1:0] o_count;
   logic             o_empty;
   logic             o_full;
   logic             o_ovf;

   bus_fifo_feeder #(.DEPTH(DEPTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_D     (i_D),
      .i_hold  (i_hold),
      .o_E     (o_E),
      .o_D     (o_D),
      .o_count (o_count),
      .o_empty (o_empty),
      .o_full  (o_full),
      .o_ovf   (o_ovf)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: occupancy, expected enable, sticky overflow, scoreboard.
   Bus_t        sb [$];
   int unsigned m_count;
   logic        m_e;
   logic        m_ovf;
   logic        m_wr;
   logic        m_rd;
   int unsigned drained;
   Bus_t        last_drained;

   assign m_wr = i_valid && (m_count < DEPTH);
   assign m_rd = (m_count > 0) && !i_hold;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_count <= 0;
         m_e     <= 1'b0;
         m_ovf   <= 1'b0;
         sb.delete();
      end else begin
         if (m_wr) sb.push_back(i_D);
         if (i_valid && (m_count == DEPTH)) m_ovf <= 1'b1;
         m_e     <= m_rd;
         m_count <= m_count + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
      end
   end

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         check_eq("o_count", 32'(o_count), m_count);
         check_eq("count_le_depth", 32'(o_count <= CNT_W'(DEPTH)), 1);
         check_eq("o_E", 32'(o_E), 32'(m_e));
         check_eq("o_ovf", 32'(o_ovf), 32'(m_ovf));
         check_eq("o_full", 32'(o_full), 32'(m_count == DEPTH));
         check_eq("o_empty", 32'(o_empty), 32'(m_count == 0));
         check_eq("o_ready", 32'(o_ready), 32'(m_count != DEPTH));
         if (o_E) begin
            if (sb.size() == 0) begin
               check_eq("spurious_E", 1, 0);
            end else begin
               check_eq("o_D", 32'(o_D), 32'(sb.pop_front()));
            end
            drained++;
            last_drained = o_D;
         end
      end
   end

   task automatic step(input logic v, input logic [11:0] d, input logic h);
      i_valid = v;
      i_D     = d;
      i_hold  = h;
      @(negedge i_clk);
   endtask

   task automatic drain(input int unsigned max_cycles);
      int unsigned k = 0;
      while ((sb.size() != 0 || m_count != 0) && k < max_cycles) begin
         step(1'b0, 12'h000, 1'b0);
         k++;
      end
      check_eq("drain_done", 32'(sb.size() + m_count), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_E"}, 32'(o_E), 0);
      check_eq({tag, "_D"}, 32'(o_D), 0);
      check_eq({tag, "_count"}, 32'(o_count), 0);
      check_eq({tag, "_ovf"}, 32'(o_ovf), 0);
      check_eq({tag, "_empty"}, 32'(o_empty), 1);
      check_eq({tag, "_full"}, 32'(o_full), 0);
      check_eq({tag, "_ready"}, 32'(o_ready), 1);
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned n;
      int unsigned guard;
      drained = 0;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_D     = '0;
      i_hold  = 1'b0;
      repeat (2) @(negedge i_clk);
      check_reset_state("reset");
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Three back-to-back words with no hold.
      base = drained;
      step(1'b1, 12'hA01, 1'b0);
      step(1'b1, 12'hB02, 1'b0);
      step(1'b1, 12'hC03, 1'b0);
      drain(10);
      check_eq("burst3_drained", drained - base, 3);

      // Fill under hold, then one refused write.
      for (int i = 0; i < 8; i++) step(1'b1, 12'h100 + 12'(i), 1'b1);
      check_eq("fill_full", 32'(o_full), 1);
      check_eq("fill_E", 32'(o_E), 0);
      step(1'b1, 12'hFFF, 1'b1);
      check_eq("ovf_set", 32'(o_ovf), 1);
      check_eq("ovf_count", 32'(o_count), 8);

      // Release with valid: read only, then read and write.
      base = drained;
      step(1'b1, 12'h200, 1'b0);
      check_eq("rel1_count", 32'(o_count), 7);
      step(1'b1, 12'h200, 1'b0);
      check_eq("rel2_count", 32'(o_count), 7);
      drain(20);
      check_eq("rel_drained", drained - base, 9);
      check_eq("rel_last", 32'(last_drained), 32'h200);

      // Wrap-around with random hold.
      base  = drained;
      n     = 0;
      guard = 0;
      while (n < 20 && guard < 500) begin
         if (m_count < DEPTH) begin
            step(1'b1, 12'h300 + 12'(n), 1'($urandom_range(0, 2) == 0));
            n++;
         end else begin
            step(1'b0, 12'h000, 1'($urandom_range(0, 1)));
         end
         guard++;
      end
      check_eq("wrap_pushed", n, 20);
      drain(40);
      check_eq("wrap_drained", drained - base, 20);
      check_eq("wrap_last", 32'(last_drained), 32'h313);

      // Reset mid-drain with five words still buffered.
      for (int i = 0; i < 6; i++) step(1'b1, 12'h400 + 12'(i), 1'b1);
      step(1'b0, 12'h000, 1'b0);
      check_eq("pre_rst_count", 32'(o_count), 5);
      check_eq("pre_rst_E", 32'(o_E), 1);
      #2 i_rst_n = 1'b0;
      #1 check_reset_state("midrst");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      base = drained;
      step(1'b1, 12'h0AA, 1'b0);
      drain(10);
      check_eq("post_rst_drained", drained - base, 1);
      check_eq("post_rst_first", 32'(last_drained), 32'h0AA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
